fifo_burst_reader: RTL and testbench

- Drains a show-ahead (prefetch) FIFO read port in bursts of a requested length.
- Re-issues the words on a valid/ready stream with a last flag.
- Sits between the video line FIFOs and downstream consumers such as the DDR write-burst engine and the pixel pipeline.
- FIFO pop is driven from registered state only, so the downstream ready has no combinational path into the FIFO control.

---
 rtl/fifo_burst_reader_pkg.sv | 21 ++
 rtl/fifo_burst_reader_skid.sv | 110 +++++++++++
 rtl/fifo_burst_reader.sv | 145 ++++++++++++++
 tb/tb_fifo_burst_reader.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_burst_reader_pkg.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader_pkg
//   Shared definitions for the burst reader and its output skid buffer.
//   - state_t    : burst reader FSM encoding
//   - SKID_DEPTH : number of {last, data} entries held between the FIFO pop
//                  and the downstream valid/ready stream
//   - OCC_WIDTH  : width needed to count 0..SKID_DEPTH entries
// -----------------------------------------------------------------------------
package fifo_burst_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int SKID_DEPTH = 2;
    localparam int OCC_WIDTH  = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/fifo_burst_reader_skid.sv
// -----------------------------------------------------------------------------
// burst_skid_buf
//   Two-entry register FIFO carrying {last, data}. Entry 0 is always the head
//   and drives head_last/head_data directly, so the outputs are pure flops.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   clr             : drop all entries (wins over push and pop)
//   push            : write push_last/push_data at the tail
//   push_last       : last flag of the pushed word
//   push_data       : pushed word
//   pop             : remove the head entry (ignored when empty)
//   occ             : registered number of valid entries (0..SKID_DEPTH)
//   head_last       : last flag of the head entry
//   head_data       : head word
// -----------------------------------------------------------------------------
module burst_skid_buf
    import fifo_burst_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  push,
    input  logic                  push_last,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [OCC_WIDTH-1:0]  occ,
    output logic                  head_last,
    output logic [DATA_WIDTH-1:0] head_data
);

    logic [OCC_WIDTH-1:0]  occ_q, occ_d;
    logic [DATA_WIDTH-1:0] data0_q, data0_d;
    logic [DATA_WIDTH-1:0] data1_q, data1_d;
    logic                  last0_q, last0_d;
    logic                  last1_q, last1_d;
    logic                  do_pop;
    logic                  do_push;

    assign do_pop  = pop & (occ_q != '0);
    // A push into a full buffer is only legal when the head leaves this cycle.
    assign do_push = push & ((occ_q < OCC_WIDTH'(SKID_DEPTH)) | do_pop);

    always_comb begin
        occ_d   = occ_q;
        data0_d = data0_q;
        data1_d = data1_q;
        last0_d = last0_q;
        last1_d = last1_q;
        if (clr) begin
            occ_d = '0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (occ_q == '0) begin
                        data0_d = push_data;
                        last0_d = push_last;
                    end else begin
                        data1_d = push_data;
                        last1_d = push_last;
                    end
                    occ_d = occ_q + OCC_WIDTH'(1);
                end
                2'b01: begin
                    data0_d = data1_q;
                    last0_d = last1_q;
                    occ_d   = occ_q - OCC_WIDTH'(1);
                end
                2'b11: begin
                    // Occupancy is unchanged; the new word lands behind
                    // whatever remains after the head leaves.
                    if (occ_q == OCC_WIDTH'(1)) begin
                        data0_d = push_data;
                        last0_d = push_last;
                    end else begin
                        data0_d = data1_q;
                        last0_d = last1_q;
                        data1_d = push_data;
                        last1_d = push_last;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q   <= '0;
            data0_q <= '0;
            data1_q <= '0;
            last0_q <= 1'b0;
            last1_q <= 1'b0;
        end else begin
            occ_q   <= occ_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
            last0_q <= last0_d;
            last1_q <= last1_d;
        end
    end

    assign occ       = occ_q;
    assign head_last = last0_q;
    assign head_data = data0_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader
//   Drains a show-ahead FIFO read port in bursts of burst_len words and
//   re-issues them on a valid/ready stream with a last flag. The FIFO pop is
//   derived from registered state (FSM, fetch counter, skid occupancy) and
//   the FIFO head valid only; m_ready never reaches fifo_rd_en.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start; fetch counter idle
//   FETCH | popping FIFO words into the skid buffer, fetch_cnt counts down
//   DRAIN | all words popped; waiting for the last word to be accepted
//   DONE  | one-cycle done pulse; start is ignored here
//
// Ports
//   clk, rst    : clock (shared with FIFO read side), sync active-high reset
//   start       : one-cycle burst request, ignored while not IDLE
//   burst_len   : words per burst, 0 means 2**LEN_WIDTH
//   abort       : cancel the burst, drop buffered words
//   busy        : burst in progress (FETCH or DRAIN)
//   done        : one-cycle pulse after the last word is accepted
//   fifo_data   : FIFO head word
//   fifo_vld    : FIFO head valid
//   fifo_rd_en  : FIFO pop
//   m_data      : output word
//   m_valid     : output valid
//   m_last      : final word of the burst
//   m_ready     : downstream accept
// -----------------------------------------------------------------------------
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_vld,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready
);

    // One extra bit so a zero length can load the full 2**LEN_WIDTH count.
    localparam int CNT_WIDTH = LEN_WIDTH + 1;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [CNT_WIDTH-1:0] load_cnt;
    logic [OCC_WIDTH-1:0] occ;
    logic                 rd_en;
    logic                 last_pop;
    logic                 skid_clr;
    logic                 skid_pop;
    logic                 head_last;

    assign load_cnt = (burst_len == '0) ? {1'b1, {LEN_WIDTH{1'b0}}}
                                        : {1'b0, burst_len};

    assign rd_en    = (state_q == FETCH) & fifo_vld & (fetch_cnt_q != '0)
                    & (occ < OCC_WIDTH'(SKID_DEPTH)) & ~abort;
    assign last_pop = rd_en & (fetch_cnt_q == CNT_WIDTH'(1));
    assign skid_clr = abort & (state_q != IDLE);
    assign skid_pop = m_valid & m_ready;

    always_comb begin
        state_d     = state_q;
        fetch_cnt_d = fetch_cnt_q;
        case (state_q)
            IDLE: begin
                if (start & ~abort) begin
                    state_d     = FETCH;
                    fetch_cnt_d = load_cnt;
                end
            end
            FETCH: begin
                if (abort) begin
                    state_d     = IDLE;
                    fetch_cnt_d = '0;
                end else begin
                    if (rd_en) begin
                        fetch_cnt_d = fetch_cnt_q - CNT_WIDTH'(1);
                    end
                    if (last_pop) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (skid_pop & m_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            fetch_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    burst_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .clr       (skid_clr),
        .push      (rd_en),
        .push_last (last_pop),
        .push_data (fifo_data),
        .pop       (skid_pop),
        .occ       (occ),
        .head_last (head_last),
        .head_data (m_data)
    );

    assign fifo_rd_en = rd_en;
    assign m_valid    = (occ != '0);
    // The stored flag may be stale after an abort; only show it with valid.
    assign m_last     = m_valid & head_last;
    assign busy       = (state_q == FETCH) | (state_q == DRAIN);
    assign done       = (state_q == DONE);

endmodule

// File: tb/tb_fifo_burst_reader.sv
module tb_fifo_burst_reader;

    localparam int DW = 32;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [LW-1:0] burst_len = '0;
    logic          abort = 1'b0;
    logic          busy;
    logic          done;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_vld = 1'b0;
    logic          fifo_rd_en;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_last;
    logic          m_ready = 1'b0;

    always #5 clk = ~clk;

    fifo_burst_reader #(
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .burst_len  (burst_len),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .fifo_data  (fifo_data),
        .fifo_vld   (fifo_vld),
        .fifo_rd_en (fifo_rd_en),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_last     (m_last),
        .m_ready    (m_ready)
    );

    // FIFO model, words not yet visible (trickle), and scoreboard of {last,data}
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] pend_q[$];
    logic [DW:0]   exp_q[$];

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int mocc    = 0;
    int pop_cnt, hs_cnt, first_pop, last_pop_c, first_hs, last_hs;
    bit exp_done     = 1'b0;
    bit stalled_prev = 1'b0;
    bit trickle_en   = 1'b0;
    bit rdy_pat      = 1'b0;
    bit last_rd      = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0b, expected %0b", tag, obs, exp);
        end
    endtask

    task automatic checkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checki(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs == exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        pop_cnt    = 0;
        hs_cnt     = 0;
        first_pop  = 0;
        last_pop_c = 0;
        first_hs   = 0;
        last_hs    = 0;
    endtask

    // One clock cycle: present FIFO head, settle, check, clock, update model.
    task automatic cycle();
        logic        rd;
        logic        hs;
        logic [DW:0] e;
        e = '0;
        if (rdy_pat) m_ready = (cyc % 3 == 0);
        fifo_vld  = (fifo_q.size() != 0);
        fifo_data = fifo_vld ? fifo_q[0] : '0;
        #1;
        check1("m_valid_vs_occ", m_valid, mocc != 0);
        check1("occ_le_2", mocc <= 2, 1'b1);
        if (mocc == 2) check1("no_pop_when_full", fifo_rd_en, 1'b0);
        if (fifo_rd_en) check1("pop_needs_vld", fifo_vld, 1'b1);
        check1("done_pulse", done, exp_done);
        if (stalled_prev) begin
            checkd("hold_data", m_data, prev_data);
            check1("hold_last", m_last, prev_last);
        end
        hs = m_valid & m_ready;
        rd = fifo_rd_en;
        if (hs) begin
            check1("word_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checkd("m_data", m_data, e[DW-1:0]);
                check1("m_last", m_last, e[DW]);
            end
            if (hs_cnt == 0) first_hs = cyc;
            last_hs = cyc;
            hs_cnt++;
        end
        if (rd) begin
            if (pop_cnt == 0) first_pop = cyc;
            last_pop_c = cyc;
            pop_cnt++;
        end
        last_rd      = rd;
        stalled_prev = m_valid & ~m_ready;
        prev_data    = m_data;
        prev_last    = m_last;
        @(posedge clk);
        cyc++;
        if (rd && fifo_q.size() != 0) fifo_q.delete(0);
        if (rst || abort) begin
            mocc = 0;
            exp_q.delete();
            exp_done     = 1'b0;
            stalled_prev = 1'b0;
        end else begin
            mocc     = mocc + (rd ? 1 : 0) - (hs ? 1 : 0);
            exp_done = hs & e[DW];
        end
        if (trickle_en && (cyc % 3 == 0) && pend_q.size() != 0)
            fifo_q.push_back(pend_q.pop_front());
        #1;
    endtask

    task automatic start_burst(input int len);
        int n;
        logic [DW-1:0] src[$];
        n   = (len == 0) ? (1 << LW) : len;
        src = {fifo_q, pend_q};
        for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), src[i]});
        clear_stats();
        burst_len = LW'(len);
        start     = 1'b1;
        cycle();
        start     = 1'b0;
        check1("busy_after_start", busy, 1'b1);
    endtask

    // Returns with DONE as the current state (done visible), or flags a timeout.
    task automatic run_until_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            cycle();
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            check1("busy_during_burst", busy, 1'b1);
        end
        check1("done_seen", seen, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check1({tag, "_busy"}, busy, 1'b0);
        check1({tag, "_done"}, done, 1'b0);
        check1({tag, "_rd_en"}, fifo_rd_en, 1'b0);
        check1({tag, "_m_valid"}, m_valid, 1'b0);
        check1({tag, "_m_last"}, m_last, 1'b0);
        checkd({tag, "_m_data"}, m_data, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        cycle();

        // 1: preloaded FIFO, full throughput
        for (int i = 0; i < 8; i++) fifo_q.push_back(DW'(32'h10 + i));
        m_ready = 1'b1;
        start_burst(8);
        run_until_done(40);
        cycle();
        checki("t1_pops", pop_cnt, 8);
        checki("t1_pop_span", last_pop_c - first_pop, 7);
        checki("t1_words", hs_cnt, 8);
        checki("t1_word_span", last_hs - first_hs, 7);
        checki("t1_sb_empty", exp_q.size(), 0);

        // 2: same burst, m_ready 1,0,0 repeating
        for (int i = 0; i < 8; i++) fifo_q.push_back(DW'(32'h20 + i));
        rdy_pat = 1'b1;
        start_burst(8);
        run_until_done(80);
        cycle();
        rdy_pat = 1'b0;
        checki("t2_pops", pop_cnt, 8);
        checki("t2_words", hs_cnt, 8);
        checki("t2_sb_empty", exp_q.size(), 0);

        // 3: empty FIFO, words trickle in every third cycle
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) pend_q.push_back(DW'(32'h30 + i));
        trickle_en = 1'b1;
        start_burst(4);
        run_until_done(100);
        cycle();
        trickle_en = 1'b0;
        checki("t3_pops", pop_cnt, 4);
        checki("t3_left", fifo_q.size() + pend_q.size(), 2);
        checki("t3_sb_empty", exp_q.size(), 0);
        fifo_q.delete();
        pend_q.delete();

        // 4: burst_len 0 means 16 words, 20 available
        for (int i = 0; i < 20; i++) fifo_q.push_back(DW'(32'h40 + i));
        start_burst(0);
        run_until_done(80);
        cycle();
        checki("t4_pops", pop_cnt, 16);
        checki("t4_left", fifo_q.size(), 4);
        checki("t4_sb_empty", exp_q.size(), 0);
        fifo_q.delete();

        // 5: abort where the third pop would happen, downstream stalled
        for (int i = 0; i < 16; i++) fifo_q.push_back(DW'(32'h60 + i));
        m_ready = 1'b0;
        start_burst(8);
        cycle();
        m_ready = 1'b1;
        cycle();
        abort   = 1'b1;
        m_ready = 1'b0;
        cycle();
        check1("t5_abort_no_pop", last_rd, 1'b0);
        abort = 1'b0;
        check1("t5_m_valid", m_valid, 1'b0);
        check1("t5_busy", busy, 1'b0);
        check1("t5_done", done, 1'b0);
        checki("t5_pops", pop_cnt, 2);
        cycle();
        check1("t5_idle_busy", busy, 1'b0);
        m_ready = 1'b1;
        start_burst(2);
        run_until_done(40);
        cycle();
        checki("t5_words", hs_cnt, 2);
        checki("t5_sb_empty", exp_q.size(), 0);
        fifo_q.delete();

        // 6: reset mid-DRAIN, then start coincident with done
        for (int i = 0; i < 8; i++) fifo_q.push_back(DW'(32'h70 + i));
        m_ready = 1'b0;
        start_burst(2);
        for (int i = 0; i < 4; i++) cycle();
        check1("t6_stalled_busy", busy, 1'b1);
        rst = 1'b1;
        cycle();
        check_all_zero("t6_reset");
        rst     = 1'b0;
        m_ready = 1'b1;
        start_burst(1);
        run_until_done(40);
        start     = 1'b1;
        burst_len = LW'(3);
        cycle();
        start = 1'b0;
        check1("t6_start_in_done_busy", busy, 1'b0);
        cycle();
        check1("t6_still_idle", busy, 1'b0);
        checki("t6_no_extra_pops", fifo_q.size(), 5);
        checki("t6_sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
